cpu_ctrl_mem: RTL and testbench
===============================

CPU_CTRL_MEM -- requirements
Module: cpu_ctrl_mem

Interface
REQ-001 SHALL have parameters: N, 32, datapath width; MEM_WORDS, 64, data-memory depth in 32-bit words (power of 2).
REQ-002 SHALL have one clock and asynchronous active-low reset; ports (name direction width meaning):
- CLK input 1: clock, rising-edge active.
- rst input 1: asynchronous active-low reset.
- opcode input 6: instr[31:26].
- funct input 6: instr[5:0].
- pc_plus_4 input N: sequential PC.
- signimm input N: sign-extended immediate.
- zero_flag input 1: ALU zero.
- alu_out input N: memory byte address.
- write_data input N: store data (rt value).
- reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, jump, jal, jr output 1 each: decoded controls.
- alu_ctrl output 4: ALU operation.
- pc_branch output N: branch target.
- pc_src output 1: branch taken.
- read_data output N: memory read data.

Function
REQ-003 SHALL decode combinationally; outputs listed as (reg_write reg_dst alu_src branch mem_write mem_to_reg jump jal jr), others 0:
- R-type 000000: 1 1 0 0 0 0 0 0 0; alu_ctrl from funct.
- lw 100011: 1 0 1 0 0 1; ADD.
- sw 101011: 0 0 1 0 1 0; ADD.
- beq 000100: 0 0 0 1 0 0; SUB.
- addi 001000 ADD / andi 001100 AND / ori 001101 OR / slti 001010 SLT: reg_write=1, alu_src=1.
- j 000010: jump=1.
- jal 000011: jump=1, jal=1, reg_write=1.
REQ-004 SHALL map R-type funct to alu_ctrl: add 100000->0010, sub 100010->0110, and 100100->0000, or 100101->0001, xor 100110->0011, nor 100111->1100, slt 101010->0111.
REQ-005 SHALL treat funct 001000 (jr) as jr=1, reg_write=0, alu_ctrl=0010.
REQ-006 SHALL drive all controls 0 and alu_ctrl=0010 for any unlisted opcode or R-type funct.
REQ-007 SHALL compute pc_branch = pc_plus_4 + (signimm << 2), modulo 2^N, no carry out, combinationally.
REQ-008 SHALL compute pc_src = branch AND zero_flag.
REQ-009 SHALL index memory with alu_out[log2(MEM_WORDS)+1:2]; upper address bits and bits [1:0] ignored (aliasing/wrap).
REQ-010 SHALL read combinationally: read_data = mem[index], zero latency.
REQ-011 SHALL write write_data to mem[index] on rising CLK when mem_write=1 and rst=1.
REQ-012 SHALL on same-address read-during-write return old data before the edge and new data after.

Reset
REQ-013 SHALL, while rst=0, asynchronously clear every memory word to 0, so read_data=0.
REQ-014 SHALL drop any write whose edge coincides with rst=0; resume writes on the first rising edge with rst=1.
REQ-015 SHALL leave decoder, adder and pc_src outputs purely combinational and unaffected by rst.

Structure
REQ-016 SHALL place opcode, funct and alu_ctrl encodings in shared package cpu_ctrl_pkg.
REQ-017 SHALL implement decoding in one sub-module ctrl_decode; adder and memory stay inline.

Verification
REQ-018 Decode sweep: every opcode/funct in REQ-003..005 plus opcode 111111 -> exact control vector per table; unknown gives all 0, alu_ctrl=0010.
REQ-019 Branch: pc_plus_4=0x00000104, signimm=0xFFFFFFFF, branch via beq, zero_flag=1 -> pc_branch=0x00000100, pc_src=1; zero_flag=0 -> pc_src=0.
REQ-020 Adder wrap: pc_plus_4=0xFFFFFFFC, signimm=0x00000002 -> pc_branch=0x00000004.
REQ-021 Store/load: sw with alu_out=0x10, write_data=0xDEADBEEF, one edge; lw alu_out=0x10 -> read_data=0xDEADBEEF; alu_out=0x110 aliases to the same word; alu_out=0x13 reads the same word.
REQ-022 Reset: after writes, pull rst low mid-cycle -> read_data=0 immediately at all addresses; a sw edge during rst=0 leaves 0.
REQ-023 Non-store opcode (lw) with alu_out=0x20, write_data=0x1234 across an edge -> mem[8] unchanged.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the single-cycle control/memory slice: opcodes, R-type
// function codes, ALU operation codes and the packed control vector.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    // Field order matches the customary listing, reg_write in the MSB.
    typedef struct packed {
        logic reg_write;
        logic reg_dst;
        logic alu_src;
        logic branch;
        logic mem_write;
        logic mem_to_reg;
        logic jump;
        logic jal;
        logic jr;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Main + ALU decoder: opcode/funct to control vector and ALU operation.
// Purely combinational; unknown encodings collapse to a harmless no-op.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output logic [3:0] alu_ctrl_o
);

    ctrl_t   ctrl_s;
    alu_op_e alu_s;
    logic    rtype_ok_s;

    // R-type funct decode: ALU op and whether this funct is a register-writing op
    always_comb begin
        rtype_ok_s = 1'b1;
        alu_s      = ALU_ADD;
        case (funct_i)
            F_ADD:   alu_s = ALU_ADD;
            F_SUB:   alu_s = ALU_SUB;
            F_AND:   alu_s = ALU_AND;
            F_OR:    alu_s = ALU_OR;
            F_XOR:   alu_s = ALU_XOR;
            F_NOR:   alu_s = ALU_NOR;
            F_SLT:   alu_s = ALU_SLT;
            default: rtype_ok_s = 1'b0;
        endcase
    end

    // Main opcode decode
    always_comb begin
        ctrl_s     = '0;
        alu_ctrl_o = ALU_ADD;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i == F_JR) begin
                    ctrl_s.jr = 1'b1;
                end else if (rtype_ok_s) begin
                    ctrl_s.reg_write = 1'b1;
                    ctrl_s.reg_dst   = 1'b1;
                    alu_ctrl_o       = alu_s;
                end else begin
                    ctrl_s = '0;
                end
            end
            OP_LW: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_s.branch = 1'b1;
                alu_ctrl_o    = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
            end
            OP_ANDI: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                alu_ctrl_o       = ALU_AND;
            end
            OP_ORI: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                alu_ctrl_o       = ALU_OR;
            end
            OP_SLTI: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                alu_ctrl_o       = ALU_SLT;
            end
            // Jumps use no ALU operation, so alu_ctrl is left at zero.
            OP_J: begin
                ctrl_s.jump = 1'b1;
                alu_ctrl_o  = 4'b0000;
            end
            OP_JAL: begin
                ctrl_s.jump      = 1'b1;
                ctrl_s.jal       = 1'b1;
                ctrl_s.reg_write = 1'b1;
                alu_ctrl_o       = 4'b0000;
            end
            default: begin
                ctrl_s     = '0;
                alu_ctrl_o = ALU_ADD;
            end
        endcase
    end

    assign ctrl_o = ctrl_s;

endmodule

// File: rtl/cpu_ctrl_mem.sv
// Control decode, branch-target adder and word-addressed data memory of a
// single-cycle datapath. Memory reads are combinational; reset clears memory.
module cpu_ctrl_mem
    import cpu_ctrl_pkg::*;
#(
    parameter int N         = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [N-1:0] pc_plus_4,
    input  logic [N-1:0] signimm,
    input  logic         zero_flag,
    input  logic [N-1:0] alu_out,
    input  logic [N-1:0] write_data,
    output logic         reg_write,
    output logic         reg_dst,
    output logic         alu_src,
    output logic         branch,
    output logic         mem_write,
    output logic         mem_to_reg,
    output logic         jump,
    output logic         jal,
    output logic         jr,
    output logic [3:0]   alu_ctrl,
    output logic [N-1:0] pc_branch,
    output logic         pc_src,
    output logic [N-1:0] read_data
);

    localparam int AW = $clog2(MEM_WORDS);

    ctrl_t         ctrl_s;
    logic [AW-1:0] idx_s;
    logic [N-1:0]  mem_q [MEM_WORDS];
    logic          unused_bits_s;

    ctrl_decode u_dec (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .ctrl_o     (ctrl_s),
        .alu_ctrl_o (alu_ctrl)
    );

    assign reg_write  = ctrl_s.reg_write;
    assign reg_dst    = ctrl_s.reg_dst;
    assign alu_src    = ctrl_s.alu_src;
    assign branch     = ctrl_s.branch;
    assign mem_write  = ctrl_s.mem_write;
    assign mem_to_reg = ctrl_s.mem_to_reg;
    assign jump       = ctrl_s.jump;
    assign jal        = ctrl_s.jal;
    assign jr         = ctrl_s.jr;

    // Word offset shift drops the top two immediate bits; result wraps mod 2^N.
    assign pc_branch = pc_plus_4 + {signimm[N-3:0], 2'b00};
    assign pc_src    = ctrl_s.branch & zero_flag;

    // Byte-offset and high address bits are ignored, so addresses alias.
    assign idx_s         = alu_out[AW+1:2];
    assign unused_bits_s = ^{alu_out[N-1:AW+2], alu_out[1:0], signimm[N-1:N-2]};

    // Data memory: asynchronous clear of every word, write on rising edge
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ctrl_s.mem_write) begin
            mem_q[idx_s] <= write_data;
        end
    end

    assign read_data = mem_q[idx_s];

endmodule

// File: tb/tb_cpu_ctrl_mem.sv
// Self-checking bench for cpu_ctrl_mem: table-driven decode sweep plus
// hand-written branch, memory, aliasing and reset sequences via a scoreboard.
module tb_cpu_ctrl_mem;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [N-1:0] pc_plus_4;
    logic [N-1:0] signimm;
    logic         zero_flag;
    logic [N-1:0] alu_out;
    logic [N-1:0] write_data;
    logic         reg_write, reg_dst, alu_src, branch, mem_write;
    logic         mem_to_reg, jump, jal, jr;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] pc_branch;
    logic         pc_src;
    logic [N-1:0] read_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cpu_ctrl_mem #(.N(32), .MEM_WORDS(64)) dut (
        .CLK        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .pc_plus_4  (pc_plus_4),
        .signimm    (signimm),
        .zero_flag  (zero_flag),
        .alu_out    (alu_out),
        .write_data (write_data),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .branch     (branch),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .jump       (jump),
        .jal        (jal),
        .jr         (jr),
        .alu_ctrl   (alu_ctrl),
        .pc_branch  (pc_branch),
        .pc_src     (pc_src),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic [8:0] ctrl;     // reg_write reg_dst alu_src branch mem_write mem_to_reg jump jal jr
        logic [3:0] alu;
        bit         chk_alu;
    } dec_vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    dec_vec_t tbl [$];
    dec_vec_t dq  [$];
    sb_t      sb  [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic expect_val(input string nm, input logic [31:0] exp);
        sb_t e;
        e.name = nm;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        sb_t e;
        if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL scoreboard_empty: got %h expected an entry", act);
        end else begin
            e = sb.pop_front();
            chk(e.name, act, e.exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic [8:0] c, input logic [3:0] a, input bit ca);
        dec_vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.ctrl = c; v.alu = a; v.chk_alu = ca;
        tbl.push_back(v);
    endtask

    task automatic read_at(input string nm, input logic [31:0] addr, input logic [31:0] exp);
        alu_out = addr;
        expect_val(nm, exp);
        #1;
        pop_cmp(read_data);
    endtask

    initial begin
        dec_vec_t d;
        logic [8:0] act_ctrl;

        rst = 1'b0; opcode = 6'b111111; funct = 6'b000000;
        pc_plus_4 = '0; signimm = '0; zero_flag = 1'b0;
        alu_out = 32'h0000_0010; write_data = 32'h0000_0000;

        add_vec("r_add",  6'b000000, 6'b100000, 9'b110000000, 4'b0010, 1'b1);
        add_vec("r_sub",  6'b000000, 6'b100010, 9'b110000000, 4'b0110, 1'b1);
        add_vec("r_and",  6'b000000, 6'b100100, 9'b110000000, 4'b0000, 1'b1);
        add_vec("r_or",   6'b000000, 6'b100101, 9'b110000000, 4'b0001, 1'b1);
        add_vec("r_xor",  6'b000000, 6'b100110, 9'b110000000, 4'b0011, 1'b1);
        add_vec("r_nor",  6'b000000, 6'b100111, 9'b110000000, 4'b1100, 1'b1);
        add_vec("r_slt",  6'b000000, 6'b101010, 9'b110000000, 4'b0111, 1'b1);
        add_vec("r_jr",   6'b000000, 6'b001000, 9'b000000001, 4'b0010, 1'b1);
        add_vec("r_unk",  6'b000000, 6'b111111, 9'b000000000, 4'b0010, 1'b1);
        add_vec("lw",     6'b100011, 6'b100010, 9'b101001000, 4'b0010, 1'b1);
        add_vec("sw",     6'b101011, 6'b000000, 9'b001010000, 4'b0010, 1'b1);
        add_vec("beq",    6'b000100, 6'b000000, 9'b000100000, 4'b0110, 1'b1);
        add_vec("addi",   6'b001000, 6'b000000, 9'b101000000, 4'b0010, 1'b1);
        add_vec("andi",   6'b001100, 6'b000000, 9'b101000000, 4'b0000, 1'b1);
        add_vec("ori",    6'b001101, 6'b000000, 9'b101000000, 4'b0001, 1'b1);
        add_vec("slti",   6'b001010, 6'b000000, 9'b101000000, 4'b0111, 1'b1);
        add_vec("j",      6'b000010, 6'b000000, 9'b000000100, 4'b0000, 1'b0);
        add_vec("jal",    6'b000011, 6'b000000, 9'b100000110, 4'b0000, 1'b0);
        add_vec("op_unk", 6'b111111, 6'b100000, 9'b000000000, 4'b0010, 1'b1);

        // Reset state: memory reads zero, decoder still live while rst is low
        #3;
        read_at("reset_read", 32'h0000_0010, 32'h0);
        opcode = 6'b000100; zero_flag = 1'b1; pc_plus_4 = 32'h0000_0104; signimm = 32'hFFFF_FFFF;
        expect_val("pc_src_in_reset", 32'h1);
        #1;
        pop_cmp({31'b0, pc_src});

        // Decode sweep
        for (int i = 0; i < tbl.size(); i++) begin
            opcode = tbl[i].op;
            funct  = tbl[i].fn;
            dq.push_back(tbl[i]);
            #1;
            d = dq.pop_front();
            act_ctrl = {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, jump, jal, jr};
            chk({d.name, "_ctrl"}, {23'b0, act_ctrl}, {23'b0, d.ctrl});
            if (d.chk_alu) chk({d.name, "_alu"}, {28'b0, alu_ctrl}, {28'b0, d.alu});
        end

        // Branch target and pc_src
        opcode = 6'b000100; funct = 6'b000000;
        pc_plus_4 = 32'h0000_0104; signimm = 32'hFFFF_FFFF; zero_flag = 1'b1;
        expect_val("br_target", 32'h0000_0100);
        expect_val("br_taken", 32'h1);
        #1;
        pop_cmp(pc_branch);
        pop_cmp({31'b0, pc_src});
        zero_flag = 1'b0;
        expect_val("br_not_taken", 32'h0);
        #1;
        pop_cmp({31'b0, pc_src});
        opcode = 6'b100011; zero_flag = 1'b1;
        expect_val("no_branch_lw", 32'h0);
        #1;
        pop_cmp({31'b0, pc_src});
        pc_plus_4 = 32'hFFFF_FFFC; signimm = 32'h0000_0002;
        expect_val("adder_wrap", 32'h0000_0004);
        #1;
        pop_cmp(pc_branch);

        // Leave reset, then store/load with aliasing
        opcode = 6'b100011;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        opcode = 6'b101011; alu_out = 32'h0000_0010; write_data = 32'hDEAD_BEEF;
        read_at("rdw_old", 32'h0000_0010, 32'h0);
        @(posedge clk); #1;
        opcode = 6'b100011;
        read_at("rdw_new", 32'h0000_0010, 32'hDEAD_BEEF);
        read_at("alias_0x110", 32'h0000_0110, 32'hDEAD_BEEF);
        read_at("byte_0x13", 32'h0000_0013, 32'hDEAD_BEEF);
        read_at("other_word", 32'h0000_0014, 32'h0);

        // mem[8] written once, then lw across an edge must not disturb it
        @(negedge clk);
        opcode = 6'b101011; alu_out = 32'h0000_0020; write_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        opcode = 6'b100011; write_data = 32'h0000_1234;
        @(posedge clk); #1;
        read_at("lw_no_write", 32'h0000_0020, 32'hCAFE_F00D);
        @(negedge clk);
        opcode = 6'b101011; alu_out = 32'h0000_00FC; write_data = 32'h5555_AAAA;
        @(posedge clk); #1;
        opcode = 6'b100011;
        read_at("top_word", 32'h0000_00FC, 32'h5555_AAAA);

        // Mid-cycle reset clears all words immediately
        #2; rst = 1'b0; #1;
        read_at("rst_clr_10", 32'h0000_0010, 32'h0);
        read_at("rst_clr_20", 32'h0000_0020, 32'h0);
        read_at("rst_clr_fc", 32'h0000_00FC, 32'h0);
        @(negedge clk);
        opcode = 6'b101011; alu_out = 32'h0000_0010; write_data = 32'h0000_0077;
        @(posedge clk); #1;
        read_at("sw_in_reset", 32'h0000_0010, 32'h0);
        // First edge with rst high resumes writes
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        read_at("resume_write", 32'h0000_0010, 32'h0000_0077);
        opcode = 6'b100011;

        if (sb.size() != 0) begin
            total_cnt++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
